psum_drain_buffer: RTL



---
 rtl/psum_drain_buffer_pkg.sv | 30 +++
 rtl/psum_drain_buffer_if.sv | 41 ++++
 rtl/psum_row_bank.sv | 89 ++++++++
 rtl/psum_drain_buffer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/psum_drain_buffer_pkg.sv
// Shared tensor-core types for the partial-sum drain path.
//   SA_N / SA_DW : default systolic array dimension and element width
//   buf_state_t  : life cycle of one reassembly bank
//   rd_state_t   : read-side FSM state, exported for observation
//   row_t        : one array output row at the default geometry
//   buf_writable : true while a bank can still accept rows
package psum_drain_buffer_pkg;

    localparam int SA_N  = 4;
    localparam int SA_DW = 16;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } buf_state_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    typedef logic [SA_N*SA_DW-1:0] row_t;

    function automatic logic buf_writable(input buf_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

endpackage

// File: rtl/psum_drain_buffer_if.sv
// Row-level bus between the systolic array, the drain buffer and the
// scratchpad writeback path.
//   in_en/in_row/in_data : array output row; accepted when in_en && has_space
//   has_space            : buffer can take a row this cycle
//   out_valid/out_ready  : writeback handshake. A row transfers on a rising
//                          edge where out_valid && out_ready. Once out_valid
//                          rises, out_row/out_data/out_last hold steady until
//                          that transfer; out_valid never drops without one.
//   out_row/out_data     : emitted row index and data, element 0 in LSBs
//   out_last             : emitted row is the final row of its matrix
// Modports: slave = drain buffer, master = the environment driving it.
interface psum_drain_buffer_if
    import psum_drain_buffer_pkg::*;
#(
    parameter int N  = SA_N,
    parameter int DW = SA_DW
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic          in_en;
    logic [RW-1:0] in_row;
    logic [N*DW-1:0] in_data;
    logic          has_space;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    logic [N*DW-1:0] out_data;
    logic          out_last;

    modport slave (
        input  in_en, in_row, in_data, out_ready,
        output has_space, out_valid, out_row, out_data, out_last
    );

    modport master (
        output in_en, in_row, in_data, out_ready,
        input  has_space, out_valid, out_row, out_data, out_last
    );

endinterface

// File: rtl/psum_row_bank.sv
// One reassembly bank: N rows of storage, a row-arrival mask and the bank
// life-cycle state.
//   CLK, RST        : clock, synchronous active-high reset (state and mask only)
//   wr_en_i         : write strobe for row wr_row_i with wr_data_i
//   drain_start_i   : read side has claimed this FULL bank
//   drain_done_i    : read side emitted the last row of this bank
//   rd_row_i        : row to present on rd_data_o
//   state_o         : current bank state
//   dup_o           : current write hits a row already present (write dropped)
//   complete_o      : current write fills the last missing row
module psum_row_bank
    import psum_drain_buffer_pkg::*;
#(
    parameter int N  = SA_N,
    parameter int DW = SA_DW,
    parameter int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wr_en_i,
    input  logic [RW-1:0]   wr_row_i,
    input  logic [N*DW-1:0] wr_data_i,
    input  logic            drain_start_i,
    input  logic            drain_done_i,
    input  logic [RW-1:0]   rd_row_i,
    output logic [N*DW-1:0] rd_data_o,
    output buf_state_t      state_o,
    output logic            dup_o,
    output logic            complete_o
);

    buf_state_t      state_q, state_d;
    logic [N-1:0]    mask_q, mask_d;
    logic [N-1:0]    row_oh;
    logic            wr_ok;
    logic [N*DW-1:0] mem_q [N];

    always_comb begin
        row_oh           = '0;
        row_oh[wr_row_i] = 1'b1;

        dup_o      = wr_en_i && buf_writable(state_q) && mask_q[wr_row_i];
        wr_ok      = wr_en_i && buf_writable(state_q) && !mask_q[wr_row_i];
        complete_o = wr_ok && ((mask_q | row_oh) == '1);

        state_d = state_q;
        mask_d  = mask_q;

        if (wr_ok) begin
            if (complete_o) begin
                // Mask is cleared as the bank seals so it is ready for reuse.
                state_d = FULL;
                mask_d  = '0;
            end else begin
                state_d = FILLING;
                mask_d  = mask_q | row_oh;
            end
        end

        if (drain_start_i && (state_q == FULL)) begin
            state_d = DRAINING;
        end

        if (drain_done_i && (state_q == DRAINING)) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    // Row storage carries no reset; the mask and state decide what is valid.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem_q[wr_row_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_row_i];
    assign state_o   = state_q;

endmodule

// File: rtl/psum_drain_buffer.sv
// Partial-sum drain buffer. Collects array output rows (any order) into two
// ping-pong banks and streams each completed N x N matrix in row order.
//   CLK, RST   : clock, synchronous active-high reset
//   bus        : row input, back-pressure and writeback handshake (slave side)
//   drained    : both banks EMPTY and read FSM idle
//   err_dup    : sticky, a row index repeated within one matrix
//   err_ovf    : sticky, a row offered while has_space was low
//   rd_state_o : read FSM state
module psum_drain_buffer
    import psum_drain_buffer_pkg::*;
#(
    parameter int N  = SA_N,
    parameter int DW = SA_DW
) (
    input  logic                CLK,
    input  logic                RST,
    psum_drain_buffer_if.slave  bus,
    output logic                drained,
    output logic                err_dup,
    output logic                err_ovf,
    output rd_state_t           rd_state_o
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic          wr_sel_q;
    logic          rd_sel_q;
    rd_state_t     rd_state_q;
    logic          out_valid_q;
    logic [RW-1:0] out_row_q;
    logic          out_last_q;
    logic          err_dup_q;
    logic          err_ovf_q;

    buf_state_t      bank_state    [2];
    logic            bank_dup      [2];
    logic            bank_complete [2];
    logic [N*DW-1:0] bank_rd_data  [2];

    logic          has_space_w;
    logic          wr_fire;
    logic          wr_dup;
    logic          wr_complete;
    logic          drain_start;
    logic          drain_done;
    logic [RW-1:0] nxt_row;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        psum_row_bank #(
            .N  (N),
            .DW (DW),
            .RW (RW)
        ) u_bank (
            .CLK           (CLK),
            .RST           (RST),
            .wr_en_i       (wr_fire && (wr_sel_q == 1'(b))),
            .wr_row_i      (bus.in_row),
            .wr_data_i     (bus.in_data),
            .drain_start_i (drain_start && (rd_sel_q == 1'(b))),
            .drain_done_i  (drain_done && (rd_sel_q == 1'(b))),
            .rd_row_i      (out_row_q),
            .rd_data_o     (bank_rd_data[b]),
            .state_o       (bank_state[b]),
            .dup_o         (bank_dup[b]),
            .complete_o    (bank_complete[b])
        );
    end

    always_comb begin
        has_space_w = buf_writable(bank_state[wr_sel_q]);
        wr_fire     = bus.in_en && has_space_w;
        wr_dup      = bank_dup[wr_sel_q];
        wr_complete = bank_complete[wr_sel_q];
        drain_start = (rd_state_q == RD_IDLE) && (bank_state[rd_sel_q] == FULL);
        // out_valid is always high in STREAM, so ready alone completes a beat.
        drain_done  = (rd_state_q == RD_STREAM) && bus.out_ready && out_last_q;
        nxt_row     = out_row_q + RW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_state_q  <= RD_IDLE;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            err_dup_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            if (wr_complete) begin
                wr_sel_q <= ~wr_sel_q;
            end
            if (wr_dup) begin
                err_dup_q <= 1'b1;
            end
            if (bus.in_en && !has_space_w) begin
                err_ovf_q <= 1'b1;
            end

            case (rd_state_q)
                RD_IDLE: begin
                    if (drain_start) begin
                        rd_state_q  <= RD_STREAM;
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                        out_last_q  <= (N == 1);
                    end
                end
                RD_STREAM: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            // Always pass through IDLE: one bubble between matrices.
                            rd_state_q  <= RD_IDLE;
                            rd_sel_q    <= ~rd_sel_q;
                            out_valid_q <= 1'b0;
                            out_row_q   <= '0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_row_q  <= nxt_row;
                            out_last_q <= (nxt_row == RW'(N - 1));
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // The draining bank is never written, so its row mux is stable while held.
    assign bus.out_data  = out_valid_q ? bank_rd_data[rd_sel_q] : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_last  = out_last_q;
    assign bus.has_space = has_space_w;

    assign drained    = (bank_state[0] == EMPTY) && (bank_state[1] == EMPTY) &&
                        (rd_state_q == RD_IDLE);
    assign err_dup    = err_dup_q;
    assign err_ovf    = err_ovf_q;
    assign rd_state_o = rd_state_q;

endmodule
